// File: rtl/core_id_hazard_scoreboard.sv
// core_id_hazard_scoreboard: per-register latency scoreboard driving the ID stall
module core_id_hazard_scoreboard #(
  parameter int REG_NUM     = 32,
  parameter int LAT_W       = 3,
  parameter int STORE_SLACK = 1,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(REG_NUM)-1:0] rs1,
  input  logic                       rs1_valid,
  input  logic [$clog2(REG_NUM)-1:0] rs2,
  input  logic                       rs2_valid,
  input  logic                       rs2_store_only,
  input  logic                       id_valid,
  input  logic                       id_issue,
  input  logic [$clog2(REG_NUM)-1:0] id_rd,
  input  logic                       id_reg_write,
  input  logic [LAT_W-1:0]           id_lat,
  input  logic                       wb_valid,
  input  logic [$clog2(REG_NUM)-1:0] wb_rd,
  input  logic                       flush,
  output logic                       insert_nop,
  output logic [REG_NUM-1:0]         busy_mask,
  output logic [CNT_W-1:0]           stall_cycles
);
  localparam int AW = $clog2(REG_NUM);
  localparam logic [LAT_W-1:0] LAT_UNK = '1;
  localparam logic [LAT_W-1:0] SLACK = LAT_W'(STORE_SLACK);
  logic [LAT_W-1:0] cnt [REG_NUM];
  logic [REG_NUM-1:0] young;
  logic [LAT_W-1:0] c1, c2;
  logic h1, h2, alloc;
  // hazard detection uses only registered state and ID sources, never wb_* or id_rd
  always_comb begin
    c1 = cnt[rs1];
    c2 = cnt[rs2];
    h1 = rs1_valid && rs1 != '0 && c1 != '0;
    h2 = rs2_valid && rs2 != '0 && c2 != '0 &&
         !(rs2_store_only && c2 != LAT_UNK && c2 <= SLACK);
    insert_nop = id_valid && !flush && (h1 || h2);
    alloc = id_issue && !flush && !insert_nop && id_reg_write && id_rd != '0;
  end
  // x0 is never tracked, so its bit is tied low
  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < REG_NUM; i++) busy_mask[i] = cnt[i] != '0;
  end
  // counter update: flush of young entry, then allocation, then writeback, then countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
      young <= '0;
      stall_cycles <= '0;
    end else begin
      stall_cycles <= stall_cycles + CNT_W'(insert_nop);
      for (int i = 1; i < REG_NUM; i++) begin
        young[i] <= 1'b0;
        if (flush && young[i]) cnt[i] <= '0;
        else if (alloc && id_rd == AW'(i)) begin
          cnt[i] <= id_lat;
          young[i] <= id_lat != '0;
        end else if (wb_valid && wb_rd == AW'(i) && cnt[i] == LAT_UNK) cnt[i] <= '0;
        else if (cnt[i] != '0 && cnt[i] != LAT_UNK) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_core_id_hazard_scoreboard.sv
// tb_core_id_hazard_scoreboard: directed checks of stall, flush, writeback and reset behaviour
module tb_core_id_hazard_scoreboard;
  logic clk = 0, rst_n = 0;
  logic [4:0] rs1, rs2, id_rd, wb_rd;
  logic rs1_valid, rs2_valid, rs2_store_only, id_valid, id_issue, id_reg_write, wb_valid, flush;
  logic [2:0] id_lat;
  logic insert_nop;
  logic [31:0] busy_mask, stall_cycles;
  int checks = 0, failures = 0;

  core_id_hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs1_valid(rs1_valid), .rs2(rs2), .rs2_valid(rs2_valid),
    .rs2_store_only(rs2_store_only), .id_valid(id_valid), .id_issue(id_issue), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_lat(id_lat), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .insert_nop(insert_nop), .busy_mask(busy_mask), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {rs1, rs2, id_rd, wb_rd} = '0;
    {rs1_valid, rs2_valid, rs2_store_only, id_issue, id_reg_write, wb_valid, flush} = '0;
    id_valid = 1;
    id_lat = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
    idle();
    id_issue = 1;
    id_reg_write = 1;
    id_rd = rd;
    id_lat = lat;
  endtask

  initial begin
    idle();
    #12;
    chk("rst_nop", insert_nop, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", stall_cycles, 0);
    tick();
    rst_n = 1;
    issue(5, 2);
    #2 chk("ld_issue_nop", insert_nop, 0);
    tick();
    idle(); rs1 = 5; rs1_valid = 1;
    #2 chk("ld_use1", insert_nop, 1);
    chk("ld_busy", busy_mask, 32'h20);
    tick();
    #2 chk("ld_use2", insert_nop, 1);
    tick();
    #2 chk("ld_use3", insert_nop, 0);
    chk("ld_stall", stall_cycles, 2);
    tick();
    issue(5, 2);
    tick();
    idle(); rs2 = 5; rs2_valid = 1; rs2_store_only = 1;
    #2 chk("st_cnt2", insert_nop, 1);
    tick();
    #2 chk("st_cnt1", insert_nop, 0);
    chk("st_busy1", busy_mask, 32'h20);
    tick();
    #2 chk("st_busy0", busy_mask, 0);
    chk("st_stall", stall_cycles, 3);
    issue(7, 3'd7);
    tick();
    idle(); rs1 = 7; rs1_valid = 1;
    for (int k = 1; k < 20; k++) begin
      #2 chk($sformatf("div_hold%0d", k), insert_nop, 1);
      tick();
    end
    wb_valid = 1; wb_rd = 7;
    #2 chk("div_wb_cycle", insert_nop, 1);
    chk("div_busy", busy_mask, 32'h80);
    tick();
    wb_valid = 0;
    #2 chk("div_release", insert_nop, 0);
    chk("div_busy_clr", busy_mask, 0);
    chk("div_stall", stall_cycles, 23);
    issue(4, 3'd7);
    tick();
    issue(3, 2);
    tick();
    idle(); flush = 1; rs1 = 3; rs1_valid = 1;
    #2 chk("fl_nop", insert_nop, 0);
    chk("fl_busy_pre", busy_mask, 32'h18);
    tick();
    flush = 0;
    #2 chk("fl_nostall", insert_nop, 0);
    chk("fl_busy_post", busy_mask, 32'h10);
    issue(9, 3'd7);
    tick();
    issue(9, 0); wb_valid = 1; wb_rd = 9;
    tick();
    idle();
    #2 chk("waw_busy", busy_mask, 32'h10);
    wb_valid = 1; wb_rd = 9;
    tick();
    idle();
    #2 chk("late_wb", busy_mask, 32'h10);
    issue(6, 3);
    tick();
    idle(); wb_valid = 1; wb_rd = 6;
    tick();
    idle();
    #2 chk("wb_ignored", busy_mask, 32'h50);
    wb_valid = 1; wb_rd = 4;
    tick();
    idle();
    #2 chk("x4_wb", busy_mask, 32'h40);
    issue(0, 3);
    tick();
    idle();
    tick();
    #2 chk("rd0_busy", busy_mask, 0);
    chk("pre6_stall", stall_cycles, 23);
    issue(10, 3);
    tick();
    issue(11, 3'd7);
    tick();
    idle(); rs1 = 11; rs1_valid = 1;
    tick();
    tick();
    #2 chk("pre_rst_stall", stall_cycles, 25);
    chk("pre_rst_busy", busy_mask, 32'h800);
    rst_n = 0;
    #1 chk("arst_nop", insert_nop, 0);
    chk("arst_busy", busy_mask, 0);
    chk("arst_stall", stall_cycles, 0);
    tick();
    rst_n = 1;
    #2 chk("post_rst_nop", insert_nop, 0);
    tick();
    #2 chk("post_rst_stall", stall_cycles, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
